// File: rtl/joy_db9md_scan.sv
// Time-multiplexed Mega Drive pad reader for one shared DB9/SNAC bus.
// Scans NPORTS pads in turn, detecting presence and 3/6-button type per port.
module joy_db9md_scan #(
  parameter int NPORTS   = 2,
  parameter int STEP_CYC = 400,
  parameter int IDLE_CYC = 80000
) (
  input  logic                                       clk,
  input  logic                                       reset_n,
  input  logic                                       scan_en,
  input  logic [5:0]                                 joy_in,
  output logic                                       joy_mdsel,
  output logic [((NPORTS > 1) ? $clog2(NPORTS) : 1)-1:0] port_sel,
  output logic [12*NPORTS-1:0]                       joystick,
  output logic [NPORTS-1:0]                          pad_present,
  output logic [NPORTS-1:0]                          pad_6btn,
  output logic                                       frame_done
);

  // state  | meaning
  // IDLE   | select high so 6-button pads reset; counts IDLE_CYC clocks
  // SCAN   | eight select phases of STEP_CYC clocks, sampling on the last clock
  // COMMIT | one clock: publish scratch to the current port, advance port_sel

  localparam int PW   = (NPORTS > 1) ? $clog2(NPORTS) : 1;
  localparam int CMAX = (STEP_CYC > IDLE_CYC) ? STEP_CYC : IDLE_CYC;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [CW-1:0] STEP_LAST = CW'(STEP_CYC - 1);
  localparam logic [CW-1:0] IDLE_LAST = CW'(IDLE_CYC - 1);
  localparam logic [PW-1:0] PORT_LAST = PW'(NPORTS - 1);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_COMMIT} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2:0]           phase_q, phase_d;
  logic [11:0]          word_q, word_d;
  logic                 present_q, present_d;
  logic                 six_q, six_d;
  logic                 mdsel_q, mdsel_d;
  logic [PW-1:0]        port_q, port_d;
  logic [12*NPORTS-1:0] joy_q, joy_d;
  logic [NPORTS-1:0]    pres_q, pres_d;
  logic [NPORTS-1:0]    btn6_q, btn6_d;
  logic                 done_q, done_d;

  logic [5:0] in_hi;
  logic       step_end;
  logic       idle_end;

  assign in_hi    = ~joy_in;
  assign step_end = (cnt_q == STEP_LAST);
  assign idle_end = (cnt_q == IDLE_LAST);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    phase_d   = phase_q;
    word_d    = word_q;
    present_d = present_q;
    six_d     = six_q;
    port_d    = port_q;
    joy_d     = joy_q;
    pres_d    = pres_q;
    btn6_d    = btn6_q;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!idle_end) begin
          cnt_d = cnt_q + 1'b1;
        end else if (scan_en) begin
          state_d   = S_SCAN;
          cnt_d     = '0;
          phase_d   = 3'd0;
          word_d    = 12'h000;
          present_d = 1'b0;
          six_d     = 1'b0;
        end
      end

      S_SCAN: begin
        if (!step_end) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          cnt_d   = '0;
          phase_d = phase_q + 3'd1;
          if (phase_q == 3'd7) state_d = S_COMMIT;
          case (phase_q)
            3'd0: word_d[5:0] = {in_hi[5], in_hi[4], in_hi[0], in_hi[1], in_hi[2], in_hi[3]};
            3'd1: begin
              // Left and Right both low while select is low marks a pad
              present_d   = (joy_in[3:2] == 2'b00);
              word_d[7:6] = in_hi[5:4];
            end
            3'd5: six_d = (joy_in[3:0] == 4'h0);
            3'd6: if (six_q) word_d[11:8] = {in_hi[0], in_hi[1], in_hi[2], in_hi[3]};
            default: ;
          endcase
        end
      end

      S_COMMIT: begin
        joy_d[12*port_q +: 12] = present_q ? (six_q ? word_q : {4'h0, word_q[7:0]}) : 12'h000;
        pres_d[port_q] = present_q;
        btn6_d[port_q] = present_q & six_q;
        done_d         = 1'b1;
        port_d         = (port_q == PORT_LAST) ? '0 : port_q + 1'b1;
        state_d        = S_IDLE;
        cnt_d          = '0;
      end

      default: state_d = S_IDLE;
    endcase

    mdsel_d = (state_d == S_SCAN) ? ~phase_d[0] : 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      phase_q   <= 3'd0;
      word_q    <= 12'h000;
      present_q <= 1'b0;
      six_q     <= 1'b0;
      mdsel_q   <= 1'b1;
      port_q    <= '0;
      joy_q     <= '0;
      pres_q    <= '0;
      btn6_q    <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      phase_q   <= phase_d;
      word_q    <= word_d;
      present_q <= present_d;
      six_q     <= six_d;
      mdsel_q   <= mdsel_d;
      port_q    <= port_d;
      joy_q     <= joy_d;
      pres_q    <= pres_d;
      btn6_q    <= btn6_d;
      done_q    <= done_d;
    end
  end

  assign joy_mdsel   = mdsel_q;
  assign port_sel    = port_q;
  assign joystick    = joy_q;
  assign pad_present = pres_q;
  assign pad_6btn    = btn6_q;
  assign frame_done  = done_q;

endmodule

// File: doc/joy_db9md_scan.md
Name: joy_db9md_scan

Overview:
- Parametrised successor to the two-pad DB9 Mega Drive reader.
- Time-multiplexes up to NPORTS Mega Drive pads over one shared 6-bit SNAC/DB9 input bus and drives the select line and the port-select lines.
- Detects pad presence and 3- versus 6-button type per port.
- Publishes debounced-by-frame, active-high 12-bit button words that the emu top ORs into joy1/joy2.

Parameters:
- NPORTS, 2: number of pads scanned (1..4).
- STEP_CYC, 400: clocks per select phase (10 us at 40 MHz).
- IDLE_CYC, 80000: clocks of idle (select high) after each port frame; must be ≥1.5 ms so 6-button pads reset their internal counter.

Ports:
- clk, input, 1: system clock (clk_sys, 35-50 MHz).
- reset_n, input, 1: synchronous active-low reset.
- scan_en, input, 1: scanning enable.
- joy_in, input, 6: pad lines, active-low: [0] Up, [1] Down, [2] Left, [3] Right, [4] B/A, [5] C/Start.
- joy_mdsel, output, 1: Mega Drive select line.
- port_sel, output, max(1,$clog2(NPORTS)): binary index of the pad currently routed to joy_in (drives joy_split when NPORTS=2).
- joystick, output, 12*NPORTS: per-port word, port k at [12k+11:12k], active-high: [0]R [1]L [2]D [3]U [4]B [5]C [6]A [7]Start [8]Mode [9]X [10]Y [11]Z.
- pad_present, output, NPORTS: pad detected on port k.
- pad_6btn, output, NPORTS: 6-button pad detected on port k.
- frame_done, output, 1: one-cycle pulse when a port's outputs update.

Behaviour:
- Reset (reset_n=0 on a clk edge): state IDLE, counter 0, joy_mdsel=1, port_sel=0, joystick=0, pad_present=0, pad_6btn=0, frame_done=0. Any partial frame is discarded.
- States:
  - IDLE: joy_mdsel=1; counts IDLE_CYC clocks. At terminal count, goes to SCAN phase 0 if scan_en=1; otherwise holds IDLE with counter at terminal.
  - SCAN: phases p=0..7, each STEP_CYC clocks; joy_mdsel = ~p[0] (phase 0 high, 1 low, ...).
- Sampling: joy_in is sampled on the last clock of each phase (counter == STEP_CYC-1) into a scratch register; inputs are inverted to active-high.
  - p0 (sel=1): U, D, L, R, B (in[4]), C (in[5]).
  - p1 (sel=0): presence = in[2]==0 && in[3]==0; A (in[4]), Start (in[5]).
  - p2–p4: ignored.
  - p5 (sel=0): six = in[0..3] all 0.
  - p6 (sel=1): Z=~in[0], Y=~in[1], X=~in[2], Mode=~in[3], captured only if six.
  - p7: ignored.
- Commit: on the clock after the p7 sample, in one cycle:
  - joystick[port_sel] <= present ? word : 0; mode/X/Y/Z bits forced 0 unless six.
  - pad_present[port_sel] <= present; pad_6btn[port_sel] <= present & six.
  - frame_done=1 for that cycle.
  - port_sel <= (port_sel==NPORTS-1) ? 0 : port_sel+1.
  - Enter IDLE with counter 0.
- Other ports' outputs are never touched during a commit; outputs are only ever written at commit, never mid-frame.
- scan_en deassert mid-SCAN: the current frame completes and commits; the block then parks in IDLE. Outputs hold last values.
- port_sel changes only at commit, so the pad is settled for the whole IDLE before its next frame.
- NPORTS=1: port_sel is constant 0.
- Counter width is $clog2(max(STEP_CYC,IDLE_CYC)+1); no wrap beyond terminal.
- Frame period per port = NPORTS*(8*STEP_CYC+IDLE_CYC+1) clocks.

Test Plan:
- Reset: hold reset_n=0 mid-frame, release -> all outputs 0, joy_mdsel=1, port_sel=0. First select falling edge occurs exactly IDLE_CYC+STEP_CYC clocks after release.
- 3-button pad on port 0 (STEP_CYC=4, IDLE_CYC=16), model holding A+Right -> after commit joystick[11:0]=12'h041, pad_present=01, pad_6btn=00, frame_done one cycle.
- 6-button model on port 1 holding X+Start+Up -> joystick[23:12]=12'h288, pad_6btn[1]=1. Same model without IDLE ≥ threshold cannot be distinguished, so the bench also checks that joy_mdsel stays high for exactly IDLE_CYC clocks between frames.
- No pad (all lines pulled high) -> joystick word 0, pad_present bit 0, even when p0 lines read high.
- Pad unplugged after a valid frame -> next commit for that port clears its word and flags; the other port's word is unchanged.
- scan_en dropped during phase 3 -> the frame still commits with frame_done; joy_mdsel then stays 1 and port_sel stays put until scan_en=1, and the next frame starts on the following clock.
